// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU instruction-memory path and its loader.
// No logic: IMEM geometry, loader state encoding, IMEM write-port bundle,
// and a helper that clamps a requested word count to the IMEM depth.
package cpu_pkg;

  localparam int IMEM_DEPTH  = 256;
  localparam int IMEM_ADDR_W = 8;
  localparam int WORD_W      = 32;

  // Depth expressed in the width of the word/clear counters (one bit wider
  // than an address so that a count of IMEM_DEPTH is representable).
  localparam logic [IMEM_ADDR_W:0] IMEM_DEPTH_W = (IMEM_ADDR_W+1)'(IMEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } ldr_state_t;

  typedef struct packed {
    logic                   we;
    logic [IMEM_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]      dat;
  } imem_wr_t;

  function automatic logic [IMEM_ADDR_W:0] clamp_words(input logic [IMEM_ADDR_W:0] n);
    if (n > IMEM_DEPTH_W) return IMEM_DEPTH_W;
    return n;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a big-endian byte stream into 32-bit words (first byte -> [31:24]).
// Latency: word_vld pulses 1 cycle after the 4th byte is accepted.
// Backpressure: none; accepts a byte whenever byte_vld is high, including the
//   cycle in which the previous word is presented (separate output register).
// Ports: clk/rst (async active-high), clr (sync clear of partial word),
//   byte_vld/byte_dat (accepted byte), word_vld/word_dat (packed word pulse).
module word_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  // Only the first three bytes need holding; the fourth goes straight into
  // the output register together with them.
  logic [1:0]  byte_cnt;
  logic [23:0] pack_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      pack_sr  <= 24'd0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else if (clr) begin
      byte_cnt <= 2'd0;
      pack_sr  <= 24'd0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (byte_vld) begin
        pack_sr  <= {pack_sr[15:0], byte_dat};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          word_vld <= 1'b1;
          word_dat <= {pack_sr, byte_dat};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills the 256x32 IMEM: zero-clears every word, then writes a program
//   streamed in as bytes from address 0, then raises start_o to the CPU.
// Latency: clear pass is IMEM_DEPTH cycles; each word is written 1 cycle
//   after its 4th byte is accepted.
// Backpressure: byte_ready_o high only in LOAD while words remain to be packed.
// Ports: clk_i, rst_i (async active-high); load_req_i/load_words_i start a
//   load; byte_valid_i/byte_i/byte_ready_o byte handshake; mem_we_o,
//   mem_addr_o, mem_data_o IMEM write port; busy_o, start_o, err_o status.
module imem_loader
  import cpu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_req_i,
  input  logic [IMEM_ADDR_W:0]   load_words_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  output logic                   byte_ready_o,
  output logic                   mem_we_o,
  output logic [IMEM_ADDR_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0]      mem_data_o,
  output logic                   busy_o,
  output logic                   start_o,
  output logic                   err_o
);

  localparam logic [IMEM_ADDR_W:0] CNT_ONE  = (IMEM_ADDR_W+1)'(1);
  localparam logic [IMEM_ADDR_W:0] CLR_LAST = IMEM_DEPTH_W - CNT_ONE;

  ldr_state_t state, state_nxt;

  // cnt is the clear address in CLEAR and the word index in LOAD.
  logic [IMEM_ADDR_W:0] cnt;
  logic [IMEM_ADDR_W:0] nwords;
  logic                 err_q;

  logic              load_go;
  logic              clear_end;
  logic              last_wr;
  logic              byte_rdy;
  logic              word_vld;
  logic [WORD_W-1:0] word_dat;
  imem_wr_t          wr;

  // A request is only honoured when no load is in progress.
  assign load_go   = load_req_i && ((state == IDLE) || (state == DONE));
  assign clear_end = (cnt == CLR_LAST);
  // Write of the final word: no further bytes may be taken from this cycle on.
  assign last_wr   = word_vld && (cnt == nwords - CNT_ONE);

  word_packer u_packer (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (load_go),
    .byte_vld (byte_valid_i && byte_rdy),
    .byte_dat (byte_i),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (load_req_i) state_nxt = CLEAR;
      CLEAR: if (clear_end)  state_nxt = (nwords != '0) ? LOAD : DONE;
      LOAD:  if (last_wr)    state_nxt = DONE;
      DONE:  if (load_req_i) state_nxt = CLEAR;
      default:               state_nxt = IDLE;
    endcase
  end

  // Counters, latched word count and error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      nwords <= '0;
      err_q  <= 1'b0;
    end else if (load_go) begin
      cnt    <= '0;
      nwords <= clamp_words(load_words_i);
      err_q  <= (load_words_i > IMEM_DEPTH_W);
    end else if (state == CLEAR) begin
      cnt <= clear_end ? '0 : cnt + CNT_ONE;
    end else if ((state == LOAD) && word_vld) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Output decode
  always_comb begin
    wr       = '0;
    byte_rdy = 1'b0;
    busy_o   = 1'b0;
    start_o  = 1'b0;
    unique case (state)
      CLEAR: begin
        busy_o  = 1'b1;
        wr.we   = 1'b1;
        wr.addr = cnt[IMEM_ADDR_W-1:0];
      end
      LOAD: begin
        busy_o   = 1'b1;
        byte_rdy = !last_wr;
        wr.we    = word_vld;
        wr.addr  = cnt[IMEM_ADDR_W-1:0];
        wr.dat   = word_dat;
      end
      DONE:    start_o = 1'b1;
      default: ;
    endcase
  end

  assign byte_ready_o = byte_rdy;
  assign mem_we_o     = wr.we;
  assign mem_addr_o   = wr.addr;
  assign mem_data_o   = wr.dat;
  assign err_o        = err_q;

endmodule
